// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU-side memory access path and the RAM block.
// Size encodings are common to both sides of the RAM port.
package cpu_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd1;
  localparam logic [1:0] SIZE_HALF = 2'd2;

  localparam int unsigned RAM_DEPTH_DEFAULT = 2048;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } mau_state_t;

endpackage

// File: rtl/mem_req_check.sv
// Combinational legality check of a request's size and address against the RAM range.
module mem_req_check import cpu_mem_pkg::*; #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned RAM_DEPTH = RAM_DEPTH_DEFAULT
) (
  input  logic [1:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              legal_o
);

  logic [31:0] addr_ext;
  assign addr_ext = 32'(addr_i);

  always_comb begin
    legal_o = 1'b0;
    case (size_i)
      SIZE_BYTE: legal_o = (addr_ext < RAM_DEPTH);
      // Both bytes of a halfword must fall inside the RAM.
      SIZE_HALF: legal_o = (RAM_DEPTH >= 32'd2) && (addr_ext <= RAM_DEPTH - 32'd2);
      default:   legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the byte-addressed RAM port: one CPU load/store at a time,
// with range/size checking and byte zero/sign extension of load data.
module mem_access_unit import cpu_mem_pkg::*; #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned RAM_DEPTH = RAM_DEPTH_DEFAULT
) (
  input  logic              I_clk,
  input  logic              I_reset,
  input  logic              I_req_valid,
  output logic              O_req_ready,
  input  logic              I_req_write,
  input  logic [1:0]        I_req_size,
  input  logic              I_req_signed,
  input  logic [ADDR_W-1:0] I_req_addr,
  input  logic [DATA_W-1:0] I_req_wdata,
  output logic              O_resp_valid,
  output logic              O_resp_err,
  output logic [DATA_W-1:0] O_resp_data,
  output logic              O_ram_enable,
  output logic              O_ram_write,
  output logic [1:0]        O_ram_size,
  output logic [ADDR_W-1:0] O_ram_addr,
  output logic [DATA_W-1:0] O_ram_data,
  input  logic [DATA_W-1:0] I_ram_data
);

  mau_state_t        state_q, state_d;
  logic              req_signed_q;
  logic              ram_enable_q, ram_write_q;
  logic [1:0]        ram_size_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_data_q;
  logic              resp_valid_q, resp_err_q;
  logic [DATA_W-1:0] resp_data_q;

  logic              req_legal;
  logic              accept;
  logic [DATA_W-1:0] load_ext;

  mem_req_check #(
    .ADDR_W    (ADDR_W),
    .RAM_DEPTH (RAM_DEPTH)
  ) u_check (
    .size_i  (I_req_size),
    .addr_i  (I_req_addr),
    .legal_o (req_legal)
  );

  assign accept = (state_q == IDLE) && I_req_valid;

  always_comb begin
    load_ext = I_ram_data;
    if (ram_size_q == SIZE_BYTE) begin
      load_ext = {{(DATA_W-8){req_signed_q & I_ram_data[7]}}, I_ram_data[7:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (I_req_valid) state_d = req_legal ? ISSUE : DONE;
      ISSUE:   state_d = ram_write_q ? DONE : READ;
      READ:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (!I_reset) begin
      state_q      <= IDLE;
      req_signed_q <= 1'b0;
      ram_enable_q <= 1'b0;
      ram_write_q  <= 1'b0;
      ram_size_q   <= 2'd0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            resp_err_q  <= ~req_legal;
            resp_data_q <= '0;
            // Illegal requests bypass the RAM entirely; O_ram_* keep their old values.
            if (req_legal) begin
              ram_enable_q <= 1'b1;
              ram_write_q  <= I_req_write;
              ram_size_q   <= I_req_size;
              ram_addr_q   <= I_req_addr;
              ram_data_q   <= I_req_wdata;
              req_signed_q <= I_req_signed;
            end else begin
              resp_valid_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          ram_enable_q <= 1'b0;
          if (ram_write_q) resp_valid_q <= 1'b1;
        end
        READ: begin
          resp_data_q  <= load_ext;
          resp_valid_q <= 1'b1;
        end
        DONE: begin
          resp_valid_q <= 1'b0;
        end
        default: begin
          ram_enable_q <= 1'b0;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign O_req_ready  = (state_q == IDLE);
  assign O_resp_valid = resp_valid_q;
  assign O_resp_err   = resp_err_q;
  assign O_resp_data  = resp_data_q;
  assign O_ram_enable = ram_enable_q;
  assign O_ram_write  = ram_write_q;
  assign O_ram_size   = ram_size_q;
  assign O_ram_addr   = ram_addr_q;
  assign O_ram_data   = ram_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural byte RAM attached.
module tb_mem_access_unit;
  import cpu_mem_pkg::*;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 2048;

  logic              I_clk = 1'b0;
  logic              I_reset = 1'b0;
  logic              I_req_valid = 1'b0;
  logic              O_req_ready;
  logic              I_req_write = 1'b0;
  logic [1:0]        I_req_size = 2'd0;
  logic              I_req_signed = 1'b0;
  logic [ADDR_W-1:0] I_req_addr = '0;
  logic [DATA_W-1:0] I_req_wdata = '0;
  logic              O_resp_valid;
  logic              O_resp_err;
  logic [DATA_W-1:0] O_resp_data;
  logic              O_ram_enable;
  logic              O_ram_write;
  logic [1:0]        O_ram_size;
  logic [ADDR_W-1:0] O_ram_addr;
  logic [DATA_W-1:0] O_ram_data;
  logic [DATA_W-1:0] I_ram_data = '0;

  always #5 I_clk = ~I_clk;

  mem_access_unit #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RAM_DEPTH (DEPTH)
  ) dut (
    .I_clk        (I_clk),
    .I_reset      (I_reset),
    .I_req_valid  (I_req_valid),
    .O_req_ready  (O_req_ready),
    .I_req_write  (I_req_write),
    .I_req_size   (I_req_size),
    .I_req_signed (I_req_signed),
    .I_req_addr   (I_req_addr),
    .I_req_wdata  (I_req_wdata),
    .O_resp_valid (O_resp_valid),
    .O_resp_err   (O_resp_err),
    .O_resp_data  (O_resp_data),
    .O_ram_enable (O_ram_enable),
    .O_ram_write  (O_ram_write),
    .O_ram_size   (O_ram_size),
    .O_ram_addr   (O_ram_addr),
    .O_ram_data   (O_ram_data),
    .I_ram_data   (I_ram_data)
  );

  // Byte RAM: read data appears the cycle after the enable edge. Upper byte of a
  // byte read is junk (0xA5) so the DUT's extension is actually exercised.
  logic [7:0] mem [0:DEPTH-1];
  always @(posedge I_clk) begin
    if (O_ram_enable) begin
      if (O_ram_write) begin
        mem[O_ram_addr[10:0]] <= O_ram_data[7:0];
        if (O_ram_size == SIZE_HALF) mem[O_ram_addr[10:0] + 11'd1] <= O_ram_data[15:8];
      end else if (O_ram_size == SIZE_HALF) begin
        I_ram_data <= {mem[O_ram_addr[10:0] + 11'd1], mem[O_ram_addr[10:0]]};
      end else begin
        I_ram_data <= {8'hA5, mem[O_ram_addr[10:0]]};
      end
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        err;
    logic [15:0] data;
    int          lat;
  } vec_t;

  function automatic vec_t mk(logic wr, logic [1:0] size, logic sgn, logic [15:0] addr,
                              logic [15:0] wdata, logic err, logic [15:0] data, int lat);
    vec_t v;
    v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.err = err; v.data = data; v.lat = lat;
    return v;
  endfunction

  task automatic do_req(input vec_t v, input string tag);
    int          en_cnt = 0;
    int          lat = 0;
    logic        err_s = 1'b0;
    logic [15:0] data_s = '0;
    @(negedge I_clk);
    chk({tag, " ready"}, 64'(O_req_ready), 64'd1);
    I_req_valid = 1'b1; I_req_write = v.wr; I_req_size = v.size; I_req_signed = v.sgn;
    I_req_addr = v.addr; I_req_wdata = v.wdata;
    @(posedge I_clk);
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge I_clk);
      I_req_valid = 1'b0;
      if (O_ram_enable) begin
        en_cnt++;
        chk({tag, " ram_write"}, 64'(O_ram_write), 64'(v.wr));
        chk({tag, " ram_size"}, 64'(O_ram_size), 64'(v.size));
        chk({tag, " ram_addr"}, 64'(O_ram_addr), 64'(v.addr));
        if (v.wr) chk({tag, " ram_data"}, 64'(O_ram_data), 64'(v.wdata));
      end
      if (O_resp_valid) begin
        lat = c; err_s = O_resp_err; data_s = O_resp_data;
      end
    end
    chk({tag, " latency"}, 64'(lat), 64'(v.lat));
    chk({tag, " err"}, 64'(err_s), 64'(v.err));
    chk({tag, " data"}, 64'(data_s), 64'(v.data));
    chk({tag, " enable pulses"}, 64'(en_cnt), v.err ? 64'd0 : 64'd1);
    @(negedge I_clk);
    chk({tag, " resp width"}, 64'(O_resp_valid), 64'd0);
    chk({tag, " enable after"}, 64'(O_ram_enable), 64'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " ready"}, 64'(O_req_ready), 64'd1);
    chk({tag, " resp"}, {O_resp_valid, O_resp_err, O_resp_data}, 64'd0);
    chk({tag, " ram ctl"}, {O_ram_enable, O_ram_write, O_ram_size, O_ram_addr}, 64'd0);
    chk({tag, " ram data"}, 64'(O_ram_data), 64'd0);
  endtask

  vec_t vecs [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(1'b1, SIZE_BYTE, 1'b0, 16'h0010, 16'h12AB, 1'b0, 16'h0000, 2);
    vecs[1]  = mk(1'b0, SIZE_BYTE, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h00AB, 3);
    vecs[2]  = mk(1'b1, SIZE_HALF, 1'b0, 16'h07FE, 16'hBEEF, 1'b0, 16'h0000, 2);
    vecs[3]  = mk(1'b0, SIZE_HALF, 1'b0, 16'h07FE, 16'h0000, 1'b0, 16'hBEEF, 3);
    vecs[4]  = mk(1'b0, SIZE_BYTE, 1'b0, 16'h07FE, 16'h0000, 1'b0, 16'h00EF, 3);
    vecs[5]  = mk(1'b0, SIZE_BYTE, 1'b0, 16'h07FF, 16'h0000, 1'b0, 16'h00BE, 3);
    vecs[6]  = mk(1'b1, SIZE_BYTE, 1'b0, 16'h0005, 16'h0080, 1'b0, 16'h0000, 2);
    vecs[7]  = mk(1'b0, SIZE_BYTE, 1'b1, 16'h0005, 16'h0000, 1'b0, 16'hFF80, 3);
    vecs[8]  = mk(1'b0, SIZE_BYTE, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'h0080, 3);
    vecs[9]  = mk(1'b0, SIZE_HALF, 1'b1, 16'h07FE, 16'h0000, 1'b0, 16'hBEEF, 3);
    vecs[10] = mk(1'b1, SIZE_HALF, 1'b0, 16'h07FF, 16'h1234, 1'b1, 16'h0000, 1);
    vecs[11] = mk(1'b0, SIZE_BYTE, 1'b0, 16'h0800, 16'h0000, 1'b1, 16'h0000, 1);
    vecs[12] = mk(1'b0, 2'd0,      1'b0, 16'h0010, 16'h0000, 1'b1, 16'h0000, 1);
    vecs[13] = mk(1'b1, 2'd3,      1'b0, 16'h0010, 16'h1111, 1'b1, 16'h0000, 1);
    vecs[14] = mk(1'b0, SIZE_BYTE, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1);
    vecs[15] = mk(1'b0, SIZE_BYTE, 1'b0, 16'h07FF, 16'h0000, 1'b0, 16'h00BE, 3);

    I_reset = 1'b0;
    repeat (3) @(negedge I_clk);
    chk_reset_state("reset");
    I_reset = 1'b1;

    for (int i = 0; i < 16; i++) do_req(vecs[i], $sformatf("vec%0d", i));

    // Valid held high with alternating store/load; fields scrambled while busy.
    begin
      int          acc = 0, resp_n = 0, en_n = 0, n = 0;
      logic        prev_rv = 1'b0, acc_last = 1'b0;
      logic [15:0] expq [$];
      for (int cyc = 0; cyc < 24; cyc++) begin
        @(negedge I_clk);
        if (prev_rv) chk("seq5 resp width", 64'(O_resp_valid), 64'd0);
        if (acc_last) chk("seq5 ready after accept", 64'(O_req_ready), 64'd0);
        if (O_ram_enable) begin
          en_n++;
          chk("seq5 ready in issue", 64'(O_req_ready), 64'd0);
        end
        if (O_resp_valid) begin
          resp_n++;
          chk("seq5 ready in done", 64'(O_req_ready), 64'd0);
          chk("seq5 err", 64'(O_resp_err), 64'd0);
          if (expq.size() == 0) chk("seq5 extra resp", 64'd1, 64'd0);
          else chk("seq5 data", 64'(O_resp_data), 64'(expq.pop_front()));
        end
        prev_rv = O_resp_valid;
        I_req_valid = (cyc < 10);
        acc_last = O_req_ready && I_req_valid;
        if (acc_last) begin
          acc++;
          I_req_write = (n % 2 == 0);
          I_req_size = SIZE_BYTE;
          I_req_signed = 1'b0;
          I_req_addr = 16'h0040 + 16'(n / 2);
          I_req_wdata = 16'h5500 | 16'(8'h30 + n);
          expq.push_back((n % 2 == 0) ? 16'h0000 : 16'(8'h30 + n - 1));
          n++;
        end else begin
          I_req_write = ~I_req_write;
          I_req_size = SIZE_HALF;
          I_req_addr = 16'h0100 + 16'(cyc);
          I_req_wdata = 16'hDEAD;
        end
      end
      I_req_valid = 1'b0;
      chk("seq5 accepted >= 3", 64'(acc >= 3), 64'd1);
      chk("seq5 resp count", 64'(resp_n), 64'(acc));
      chk("seq5 enable count", 64'(en_n), 64'(acc));
      chk("seq5 queue drained", 64'(expq.size()), 64'd0);
    end

    // Reset during ISSUE, then during READ of a load.
    for (int k = 1; k <= 2; k++) begin
      int rv_seen = 0;
      @(negedge I_clk);
      I_req_valid = 1'b1; I_req_write = 1'b0; I_req_size = SIZE_BYTE; I_req_signed = 1'b0;
      I_req_addr = 16'h0010;
      @(posedge I_clk);
      for (int j = 0; j < k; j++) begin
        @(negedge I_clk);
        I_req_valid = 1'b0;
        if (O_resp_valid) rv_seen++;
      end
      chk($sformatf("rst%0d enable in issue", k), 64'(O_ram_enable), (k == 1) ? 64'd1 : 64'd0);
      I_reset = 1'b0;
      @(negedge I_clk);
      chk_reset_state($sformatf("rst%0d", k));
      I_reset = 1'b1;
      repeat (4) begin
        @(negedge I_clk);
        if (O_resp_valid || O_ram_enable) rv_seen++;
      end
      chk($sformatf("rst%0d no activity", k), 64'(rv_seen), 64'd0);
    end

    do_req(mk(1'b0, SIZE_HALF, 1'b0, 16'h07FE, 16'h0000, 1'b0, 16'hBEEF, 3), "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
